// File: rtl/toonify_pkg.sv
// Shared types and constants for the toonify pixel path.
// Window index k = col*WIN_COL_STRIDE + row*WIN_ROW_STRIDE.
package toonify_pkg;
    localparam int DSIZE          = 5;
    localparam int PIX_W          = DSIZE * 3;
    localparam int WIN_N          = 25;
    localparam int WIN_ROWS       = 5;
    localparam int WIN_COL_STRIDE = 5;
    localparam int WIN_ROW_STRIDE = 1;
    localparam int LB_N           = 4;

    typedef logic [PIX_W-1:0] pixel_t;
endpackage

// File: rtl/line_delay.sv
// One-line delay: IMG_W-deep RAM, single address, read-before-write.
// Read is combinational so the chain can forward old data in the same beat.
module line_delay
    import toonify_pkg::*;
#(
    parameter int DEPTH = 800,
    parameter int W     = PIX_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] mem [DEPTH];

    assign o_rdata = mem[i_addr];

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_addr] <= i_wdata;
    end
endmodule

// File: rtl/window_5x5_gen.sv
// Raster-to-5x5 window generator for the Gaussian blur stage.
// Optional WIN_COORD_EN adds o_cx/o_cy centre-coordinate outputs.
module window_5x5_gen #(
    parameter int DSIZE = 5,
    parameter int IMG_W = 800,
    parameter int IMG_H = 600
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic                    i_sof,
    input  logic [DSIZE*3-1:0]      i_pixel,
    output logic                    o_valid,
    output logic [DSIZE*3*25-1:0]   o_window
`ifdef WIN_COORD_EN
    ,
    output logic [$clog2(IMG_W)-1:0] o_cx,
    output logic [$clog2(IMG_H)-1:0] o_cy
`endif
);
    import toonify_pkg::*;

    localparam int PW = DSIZE * 3;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [XW-1:0] px;
    logic [YW-1:0] py;

    // i_sof resyncs the accepted pixel to (0,0) in the same beat
    assign px = i_sof ? '0 : x_q;
    assign py = i_sof ? '0 : y_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (i_valid) begin
            if (px == XW'(IMG_W - 1)) begin
                x_q <= '0;
                y_q <= (py == YW'(IMG_H - 1)) ? '0 : py + 1'b1;
            end else begin
                x_q <= px + 1'b1;
                y_q <= py;
            end
        end
    end

    logic [PW-1:0] lb_rd [LB_N];
    logic [PW-1:0] lb_wd [LB_N];

    assign lb_wd[0] = i_pixel;

    for (genvar gi = 0; gi < LB_N; gi++) begin : g_lb
        if (gi > 0) begin : g_fwd
            assign lb_wd[gi] = lb_rd[gi-1];
        end
        line_delay #(
            .DEPTH (IMG_W),
            .W     (PW),
            .AW    (XW)
        ) u_lb (
            .i_clk   (i_clk),
            .i_we    (i_valid),
            .i_addr  (px),
            .i_wdata (lb_wd[gi]),
            .o_rdata (lb_rd[gi])
        );
    end

    logic          s1_valid;
    logic [PW-1:0] s1_pix;
    logic [PW-1:0] s1_col [LB_N];
    logic [XW-1:0] s1_x;
    logic [YW-1:0] s1_y;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
            for (int r = 0; r < LB_N; r++) s1_col[r] <= '0;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_pix <= i_pixel;
                s1_x   <= px;
                s1_y   <= py;
                // row 0 is the oldest line (LB3)
                for (int r = 0; r < LB_N; r++) s1_col[r] <= lb_rd[LB_N-1-r];
            end
        end
    end

    logic [PW-1:0] win [WIN_N];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            for (int k = 0; k < WIN_N; k++) win[k] <= '0;
        end else begin
            o_valid <= s1_valid && (s1_x >= XW'(4)) && (s1_y >= YW'(4));
            if (s1_valid) begin
                for (int k = 0; k < WIN_N - WIN_COL_STRIDE; k++)
                    win[k] <= win[k+WIN_COL_STRIDE];
                for (int r = 0; r < LB_N; r++)
                    win[WIN_N-WIN_COL_STRIDE+r*WIN_ROW_STRIDE] <= s1_col[r];
                win[WIN_N-1] <= s1_pix;
            end
        end
    end

`ifdef WIN_COORD_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cx <= '0;
            o_cy <= '0;
        end else if (s1_valid) begin
            o_cx <= s1_x - XW'(2);
            o_cy <= s1_y - YW'(2);
        end
    end
`endif

    for (genvar gk = 0; gk < WIN_N; gk++) begin : g_pack
        assign o_window[PW*WIN_N-1-gk*PW -: PW] = win[gk];
    end
endmodule

// File: tb/tb_window_5x5_gen.sv
// Directed bench for window_5x5_gen on an 8x6 image.
// Expected windows come from pixel coordinates (value = y*8+x).
module tb_window_5x5_gen;
    localparam int DSIZE = 5;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int PW    = DSIZE * 3;
    localparam int WW    = PW * 25;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_sof = 1'b0;
    logic [PW-1:0] i_pixel = '0;
    logic          o_valid;
    logic [WW-1:0] o_window;
`ifdef WIN_COORD_EN
    logic [XW-1:0] o_cx;
    logic [YW-1:0] o_cy;
`endif

    window_5x5_gen #(
        .DSIZE (DSIZE),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_sof    (i_sof),
        .i_pixel  (i_pixel),
        .o_valid  (o_valid),
        .o_window (o_window)
`ifdef WIN_COORD_EN
        ,
        .o_cx     (o_cx),
        .o_cy     (o_cy)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [WW-1:0] win;
        int            cyc;
        int            cx;
        int            cy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   win_cnt = 0;
    int   mx = 0;
    int   my = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk_v(input string tag, input logic [WW-1:0] obs,
                         input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] exp_window(input int x, input int y);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < 25; k++) begin
            int v;
            v = (y - 4 + k % 5) * IMG_W + (x - 4 + k / 5);
            w[WW-1-k*PW -: PW] = PW'(v);
        end
        return w;
    endfunction

    always @(negedge i_clk) begin
        if (o_valid) begin
            exp_t e;
            win_cnt++;
            chk_i("pulse_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_v("window", o_window, e.win);
                chk_i("latency", cyc, e.cyc);
`ifdef WIN_COORD_EN
                chk_i("cx", int'(o_cx), e.cx);
                chk_i("cy", int'(o_cy), e.cy);
`endif
            end
        end
    end

    task automatic drive(input bit sof, input int base);
        exp_t e;
        if (sof) begin
            mx = 0;
            my = 0;
        end
        i_valid = 1'b1;
        i_sof   = sof;
        i_pixel = PW'(base + my * IMG_W + mx);
        @(posedge i_clk);
        #1;
        if (mx >= 4 && my >= 4) begin
            e.win = exp_window(mx, my);
            e.cyc = cyc + 1;
            e.cx  = mx - 2;
            e.cy  = my - 2;
            q.push_back(e);
        end
        if (mx == IMG_W - 1) begin
            mx = 0;
            my = (my == IMG_H - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic run(input int n, input bit sof0, input bit gaps);
        for (int i = 0; i < n; i++) begin
            drive(sof0 && i == 0, 0);
            if (gaps && $urandom_range(0, 1) == 1)
                idle(1 + int'($urandom_range(0, 2)));
        end
    endtask

    task automatic drain(input string tag, input int wc0, input int n);
        idle(4);
        chk_i({tag, "_queue_empty"}, q.size(), 0);
        chk_i({tag, "_windows"}, win_cnt - wc0, n);
    endtask

    int wc0;

    initial begin
        idle(3);
        chk_i("rst_valid", int'(o_valid), 0);
        chk_v("rst_window", o_window, '0);
`ifdef WIN_COORD_EN
        chk_i("rst_cx", int'(o_cx), 0);
        chk_i("rst_cy", int'(o_cy), 0);
`endif
        i_rst = 1'b0;
        idle(2);

        wc0 = win_cnt;
        run(48, 1'b1, 1'b0);
        drain("continuous", wc0, 8);

        wc0 = win_cnt;
        run(48, 1'b1, 1'b1);
        drain("gaps", wc0, 8);

        wc0 = win_cnt;
        drive(1'b1, 1000);
        for (int i = 1; i < 20; i++) drive(1'b0, 1000);
        idle(3);
        run(48, 1'b1, 1'b0);
        drain("abort", wc0, 8);

        wc0 = win_cnt;
        run(30, 1'b1, 1'b0);
        i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk_i("inrst_valid", int'(o_valid), 0);
            chk_v("inrst_window", o_window, '0);
        end
        mx = 0;
        my = 0;
        i_rst = 1'b0;
        idle(1);
        run(48, 1'b0, 1'b0);
        drain("reset_restart", wc0, 8);

        wc0 = win_cnt;
        run(96, 1'b1, 1'b0);
        drain("back_to_back", wc0, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/window_5x5_gen.md
# window_5x5_gen

Raster-to-window generator feeding the 5×5 Gaussian blur stage. Accepts one RGB pixel per valid cycle in raster order and buffers the last four image lines. Emits the packed 25-pixel neighbourhood in exactly the layout the blur consumes: column-major, index 24 = newest pixel, index 0 = oldest. Sits between the frame source (SDRAM reader / camera path) and the blur.

## Interface
Parameters:
- DSIZE, 5, bits per colour channel; a pixel is {R,G,B} of DSIZE*3 bits
- IMG_W, 800, active pixels per line (≥5)
- IMG_H, 600, active lines per frame (≥5)

Ports:
- i_clk  input  1  single clock, all logic rising-edge
- i_rst  input  1  asynchronous, active-high reset
- i_valid  input  1  i_pixel/i_sof accepted this cycle
- i_sof  input  1  qualifies i_valid: this pixel is (0,0) of a new frame
- i_pixel  input  DSIZE*3  {R,G,B} pixel
- o_valid  output  1  o_window holds a complete interior window; one-cycle pulse
- o_window  output  DSIZE*3*25  packed window; element k at bits [DSIZE*3*25-1-k*DSIZE*3 -: DSIZE*3]
- o_cx, o_cy  output  clog2(IMG_W), clog2(IMG_H)  window centre coordinate (only with WIN_COORD_EN)

## Operation
- Window element k = column k/5 (0 left/oldest … 4 right/newest), row k%5 (0 top = 4 lines ago … 4 bottom = current line).
- Counters x∈[0,IMG_W-1], y∈[0,IMG_H-1] give the position of the accepted pixel. Advance only on i_valid; x wraps to 0 with y+1; (IMG_W-1,IMG_H-1) wraps to (0,0).
- i_valid with i_sof forces this pixel to (0,0), regardless of current counters (resync). i_sof without i_valid is ignored.
- Line buffers: four one-line delays in a chain, each IMG_W×DSIZE*3, addressed by x, read-before-write. On accept: LB0[x]←i_pixel, LB1[x]←LB0 old, LB2[x]←LB1 old, LB3[x]←LB2 old.
- Window update per accept: columns 0–3 ← columns 1–4; column 4 ← {LB3 old, LB2 old, LB1 old, LB0 old, i_pixel} for rows 0..4.
- o_valid pulses for an accepted pixel iff x≥4 and y≥4. This yields (IMG_W-4)×(IMG_H-4) windows per frame; centre = (x-2, y-2). Border pixels produce no window.
- Cycles without i_valid: window, counters and buffers hold; o_valid low.
- Line buffer contents are not reset. Stale data reaches only suppressed windows (x<4 or y<4).

## Timing
- Two-stage pipeline. Stage 1: RAM read, register pixel/x/y/valid. Stage 2: window shift, o_valid.
- o_valid asserts exactly 2 cycles after the accepting i_valid edge; o_window is valid in that same cycle.
- Full throughput: one pixel per cycle, no backpressure. i_valid may toggle arbitrarily.
- Read-during-write to the same line-buffer address must return old data.
- Reset values: o_valid=0, o_window=0, o_cx=o_cy=0, x=y=0, pipeline valids=0.
- Reset mid-frame: in-flight pixels are discarded. The next accepted pixel is treated as (0,0) even without i_sof.

## Configuration
- WIN_COORD_EN defined: o_cx/o_cy ports exist and are pipelined alongside o_window, carrying the centre coordinate (x-2, y-2).
- WIN_COORD_EN undefined: the ports and their registers are absent. Window behaviour is identical.

## Structure
- Shared package `toonify_pkg`:
  - DSIZE, PIX_W = DSIZE*3, WIN_N = 25
  - `pixel_t` typedef
  - window index helper constants (column/row stride)
- Sub-module `line_delay`: a single-port-address, read-before-write RAM of IMG_W×PIX_W, instantiated 4× in a chain.

## Test plan
All scenarios use IMG_W=8, IMG_H=6; pixel value = y*8+x.
- Continuous frame, i_sof on the first pixel, 48 pixels → 8 o_valid pulses. First pulse 2 cycles after pixel 36: element0=0, element12=18, element24=36, element4=32, element20=4. Last pulse: element24=47.
- Same frame with random i_valid gaps (~50% duty) → identical 8 windows in the same order, each 2 cycles after its accepting beat.
- Abort after 20 pixels, then i_sof with a fresh frame → first window again contains element24=36, element0=0. No values from the aborted frame appear in any emitted window.
- Assert i_rst at pixel 30, then restart without i_sof → during reset o_valid=0 and o_window=0; after reset, windows match scenario 1.
- Two back-to-back frames with no idle cycles → 16 windows; the first window of frame 2 equals the first window of frame 1.
- WIN_COORD_EN defined → first window o_cx=2, o_cy=2; last window o_cx=5, o_cy=3.
